// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART frame constants, state encoding and parity type
package uart_defs;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FRAME_BITS = 11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_e;

  localparam parity_e UART_PARITY = PARITY_EVEN;

endpackage

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - start/data/parity/stop serialiser timed by the 16x sample strobe
module uart_transmitter
  import uart_defs::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Tx_sample_ENABLE,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 TxD,
  output logic                 Tx_BUSY
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;

  assign bit_end = (tick_q == TICK_LAST) && Tx_sample_ENABLE;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    busy_d    = busy_q;

    // Strobes only advance the timer while a frame is in flight.
    if (state_q != IDLE && Tx_sample_ENABLE) begin
      tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (Tx_EN && Tx_WR) begin
          shift_d   = Tx_DATA;
          parity_d  = (^Tx_DATA) ^ (UART_PARITY == PARITY_ODD);
          bit_idx_d = '0;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == BIT_LAST) begin
            txd_d   = parity_q;
            state_d = PARITY;
          end else begin
            txd_d   = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tick_d  = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmit path for the Project 2 UART, mirroring the receiver. It serialises one byte per write request into a start / 8 data / even-parity / stop frame on `TxD`. Bit timing comes from the same 16x oversampling `sample_ENABLE` strobe that `baud_controller` generates for the receiver. It sits between the system-side byte source and the physical `TxD` line.

## Interface
- `DATA_BITS`, 8 — payload width, sent LSB first.
- `OVERSAMPLE`, 16 — `Tx_sample_ENABLE` pulses per transmitted bit.
- `clk`  in  1 — single system clock; all logic on its rising edge.
- `reset`  in  1 — synchronous, active-low reset.
- `Tx_sample_ENABLE`  in  1 — one-`clk` strobe at 16x baud, from a `baud_controller` instance.
- `Tx_EN`  in  1 — transmitter enable; gates acceptance of new frames only.
- `Tx_WR`  in  1 — write request; sampled every `clk`.
- `Tx_DATA`  in  DATA_BITS — byte to send; captured when a write is accepted.
- `TxD`  out  1 — serial line; idle level is 1.
- `Tx_BUSY`  out  1 — high from the cycle after acceptance until the frame ends.

## Operation
- **Reset state** (`reset`=0 at a clock edge): state IDLE, `TxD`=1, `Tx_BUSY`=0, and the tick counter, bit index and shift register are all cleared. Reset takes priority over everything. A reset mid-frame aborts the frame with no partial stop bit.
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE.
- **Acceptance:** in IDLE, with `Tx_EN`=1 and `Tx_WR`=1:
  - latch `Tx_DATA` into the shift register;
  - latch parity = XOR of all data bits (even parity);
  - go to START.
  - A `Tx_WR` pulse outside IDLE, or with `Tx_EN`=0, is ignored and not queued.
- **Bit timer:** a 4-bit tick counter increments on each `Tx_sample_ENABLE` pulse. It is cleared on every state or bit transition.
  - A bit ends on the clock edge where the counter equals OVERSAMPLE-1 and `Tx_sample_ENABLE`=1.
- **START:** `TxD`=0 for one bit period.
- **DATA:** `TxD` = shift register bit 0.
  - At each bit end, shift right and increment a 3-bit bit index.
  - After the bit with index DATA_BITS-1, go to PARITY.
- **PARITY:** `TxD` = latched parity for one bit period.
- **STOP:** `TxD`=1 for one bit period, then go to IDLE.
- **Enable during a frame:** `Tx_EN` dropping mid-frame does not abort the frame; it completes normally.
- **Strobe rules:** `Tx_sample_ENABLE` pulses arriving in IDLE are ignored. The counter does not free-run.

## Timing
- **Output registering:** `TxD` and `Tx_BUSY` are registered outputs with no combinational path from the inputs.
- **Acceptance latency:** for acceptance at edge N, `TxD`=0 and `Tx_BUSY`=1 are visible after edge N.
- **Bit length:** each bit lasts exactly 16 `Tx_sample_ENABLE` pulses counted from its first cycle. A frame is 11×16 = 176 pulses.
- **End of frame:** at the edge ending STOP, `Tx_BUSY`=0 and `TxD`=1 take effect.
  - A `Tx_WR` presented in the same cycle as that edge is ignored, because the block is still not in IDLE.
  - A `Tx_WR` presented in the following cycle is accepted, so back-to-back frames have zero idle bits between them.
- **Simultaneous inputs:** `Tx_WR` and `Tx_sample_ENABLE` asserted together in IDLE: the write is accepted and the strobe is not counted.
- **Data stability:** `Tx_DATA` changes after acceptance have no effect on the current frame.

## Structure
- **Shared package** (`uart_defs`), also used by the receiver:
  - state encoding localparams (IDLE=0 … STOP=4);
  - `OVERSAMPLE`=16;
  - frame length 11;
  - parity type.
- **No sub-module inside the block.** Parity is a single reduction-XOR.
- **Integration:** the UART top instantiates a second `baud_controller` beside `uart_transmitter` to drive `Tx_sample_ENABLE` from the same `baud_select` as the receiver.

## Test plan
- **Reset:** hold `reset`=0 for 3 clocks with `Tx_WR`=1 → `TxD`=1 and `Tx_BUSY`=0 throughout.
- **Single frame:** `Tx_EN`=1, `Tx_WR` pulse with `Tx_DATA`=8'hA5, `Tx_sample_ENABLE` every 4 clocks.
  - `TxD` sequence, each bit held 64 clocks: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - `Tx_BUSY` high for 704 clocks.
- **Parity and back-to-back:** `Tx_DATA`=8'h07 → parity bit 1. Then 8'hFF with `Tx_WR` one cycle after `Tx_BUSY` falls → parity 0, and the second start bit begins immediately after the first stop bit.
- **Ignored writes:**
  - `Tx_WR` with `Tx_EN`=0 → no frame.
  - `Tx_WR`=1 with `Tx_DATA`=8'h00 mid-frame → current frame unchanged, no second frame.
- **Enable and reset mid-frame:**
  - drop `Tx_EN` during DATA → frame completes;
  - assert `reset`=0 during PARITY → next edge `TxD`=1, `Tx_BUSY`=0, and the next accepted write sends a full correct frame.
